// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch front end.
// Owns the fetch PC and keeps at most one instruction-bus transaction in
// flight. The returned word is held for decode until it is accepted or a
// redirect kills it. A redirect that arrives while a fetch is outstanding
// marks the response stale; the stale word is dropped and fetch resumes at
// the latest redirect target.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset          synchronous, active-high
//   redirect       next-PC mux is selecting a jump/exception target
//   pcselected     next PC from the selection mux (pcplus4 when no redirect)
//   pcplus4        pc + 4, feeds the selection mux
//   ireq_valid     instruction-bus request valid
//   ireq_addr      instruction-bus request address
//   iresp_addr_ok  bus accepted the request this cycle
//   iresp_data_ok  bus returns data this cycle
//   iresp_data     returned instruction word
//   f_valid        held instruction valid to decode
//   f_pc           PC of the held instruction
//   f_instr        held instruction word
//   f_ready        decode accepts the held instruction this cycle
module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [63:0] pcselected,
  output logic [63:0] pcplus4,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  input  logic        f_ready
);

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e      state;
  logic [63:0] pc;
  logic [63:0] tgt;
  logic        discard;
  logic [31:0] instr;
  logic        resp_now;

  // A response completes either from WAIT, or in REQ when the bus accepts
  // and answers in the same cycle. data_ok without addr_ok in REQ is ignored.
  assign resp_now = ((state == StReq) && iresp_addr_ok && iresp_data_ok) ||
                    ((state == StWait) && iresp_data_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      state   <= StReq;
      discard <= 1'b0;
      tgt     <= 64'd0;
      instr   <= 32'd0;
    end else if (resp_now) begin
      if (redirect) begin
        // Redirect coincident with the response: drop data, go to new target.
        pc      <= pcselected;
        discard <= 1'b0;
        state   <= StReq;
      end else if (discard) begin
        pc      <= tgt;
        discard <= 1'b0;
        state   <= StReq;
      end else begin
        instr <= iresp_data;
        state <= StHold;
      end
    end else begin
      unique case (state)
        StReq: begin
          // Address stays on the bus until accepted; redirect is only recorded.
          if (iresp_addr_ok) begin
            state <= StWait;
          end
          if (redirect) begin
            discard <= 1'b1;
            tgt     <= pcselected;
          end
        end
        StWait: begin
          if (redirect) begin
            discard <= 1'b1;
            tgt     <= pcselected;
          end
        end
        StHold: begin
          // Redirect takes precedence; pcselected equals pcplus4 otherwise.
          if (redirect || f_ready) begin
            pc    <= pcselected;
            state <= StReq;
          end
        end
        default: begin
          state <= StReq;
        end
      endcase
    end
  end

  assign pcplus4    = pc + 64'd4;
  assign ireq_addr  = pc;
  assign f_pc       = pc;
  assign f_instr    = instr;
  assign ireq_valid = !reset && (state == StReq);
  assign f_valid    = !reset && (state == StHold);

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [63:0] ResetPc = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WrapPc  = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk;
  logic        reset, redirect, iresp_addr_ok, iresp_data_ok, f_ready;
  logic [63:0] rtgt, pcselected, pcplus4, ireq_addr, f_pc;
  logic        ireq_valid, f_valid;
  logic [31:0] iresp_data, f_instr;

  // Second instance exercising the PC wrap
  logic        w_reset, w_addr_ok, w_data_ok, w_f_ready, w_ireq_valid, w_f_valid;
  logic [63:0] w_pcselected, w_pcplus4, w_ireq_addr, w_f_pc;
  logic [31:0] w_data, w_f_instr;

  assign pcselected   = redirect ? rtgt : pcplus4;
  assign w_pcselected = w_pcplus4;

  fetch_pc_unit #(.RESET_PC(ResetPc)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .pcselected(pcselected),
    .pcplus4(pcplus4), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data), .f_valid(f_valid), .f_pc(f_pc),
    .f_instr(f_instr), .f_ready(f_ready)
  );

  fetch_pc_unit #(.RESET_PC(WrapPc)) dut_wrap (
    .clk(clk), .reset(w_reset), .redirect(1'b0), .pcselected(w_pcselected),
    .pcplus4(w_pcplus4), .ireq_valid(w_ireq_valid), .ireq_addr(w_ireq_addr),
    .iresp_addr_ok(w_addr_ok), .iresp_data_ok(w_data_ok),
    .iresp_data(w_data), .f_valid(w_f_valid), .f_pc(w_f_pc),
    .f_instr(w_f_instr), .f_ready(w_f_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Transaction-level reference model
  logic [63:0] m_pc, m_ptgt;
  logic [31:0] m_instr;
  bit          m_out, m_held, m_pend, m_init;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ao, input logic dok, input logic [31:0] d,
                       input logic rd, input logic [63:0] rt, input logic fr);
    reset = r; iresp_addr_ok = ao; iresp_data_ok = dok; iresp_data = d;
    redirect = rd; rtgt = rt; f_ready = fr;
  endtask

  task automatic model_update();
    if (reset) begin
      m_pc = ResetPc; m_out = 0; m_held = 0; m_pend = 0; m_instr = 32'd0; m_init = 1;
    end else if (!m_init) begin
      // nothing known yet
    end else if (m_held) begin
      if (redirect) begin
        m_pc = rtgt; m_held = 0;
      end else if (f_ready) begin
        m_pc = m_pc + 64'd4; m_held = 0;
      end
    end else if (!m_out && !iresp_addr_ok) begin
      if (redirect) begin m_pend = 1; m_ptgt = rtgt; end
    end else if (iresp_data_ok) begin
      m_out = 0;
      if (redirect) begin
        m_pc = rtgt; m_pend = 0;
      end else if (m_pend) begin
        m_pc = m_ptgt; m_pend = 0;
      end else begin
        m_instr = iresp_data; m_held = 1;
      end
    end else begin
      m_out = 1;
      if (redirect) begin m_pend = 1; m_ptgt = rtgt; end
    end
  endtask

  task automatic compare_model();
    if (!m_init) return;
    chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, !reset && !m_out && !m_held});
    chk("f_valid", {63'd0, f_valid}, {63'd0, !reset && m_held});
    chk("ireq_addr", ireq_addr, m_pc);
    chk("f_pc", f_pc, m_pc);
    chk("pcplus4", pcplus4, m_pc + 64'd4);
    chk("f_instr", {32'd0, f_instr}, {32'd0, m_instr});
    chk("excl", {63'd0, ireq_valid & f_valid}, 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    m_init = 0;
    w_reset = 1; w_addr_ok = 0; w_data_ok = 0; w_data = 32'd0; w_f_ready = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    repeat (3) tick();

    // Reset and first fetch with an immediate bus
    drive(0, 1, 1, 32'h13, 0, 0, 0);
    #1;
    chk("first_req_valid", {63'd0, ireq_valid}, 64'd1);
    chk("first_req_addr", ireq_addr, 64'h8000_0000);
    tick();
    chk("first_f_valid", {63'd0, f_valid}, 64'd1);
    chk("first_f_instr", {32'd0, f_instr}, 64'h13);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("second_req_addr", ireq_addr, 64'h8000_0004);

    // Delayed bus
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) begin
      tick();
      chk("req_addr_stable", ireq_addr, 64'h8000_0004);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) begin
      tick();
      chk("no_req_in_wait", {63'd0, ireq_valid}, 64'd0);
    end
    drive(0, 0, 1, 32'h0000_000A, 0, 0, 0);
    tick();
    chk("delayed_f_valid", {63'd0, f_valid}, 64'd1);
    chk("delayed_f_instr", {32'd0, f_instr}, 64'hA);

    // Redirect in WAIT
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 64'h8000_1000, 0);
    tick();
    drive(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    tick();
    chk("wait_redir_no_fvalid", {63'd0, f_valid}, 64'd0);
    chk("wait_redir_addr", ireq_addr, 64'h8000_1000);

    // Redirect in REQ before addr_ok
    drive(0, 0, 0, 0, 1, 64'h2000, 0);
    tick();
    chk("req_redir_hold_addr", ireq_addr, 64'h8000_1000);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("req_redir_hold_addr2", ireq_addr, 64'h8000_1000);
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 32'h55, 0, 0, 0);
    tick();
    chk("req_redir_dropped", {63'd0, f_valid}, 64'd0);
    chk("req_redir_addr", ireq_addr, 64'h2000);

    // Decode stall, then redirect together with f_ready
    drive(0, 1, 1, 32'h77, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (5) begin
      tick();
      chk("stall_f_valid", {63'd0, f_valid}, 64'd1);
      chk("stall_f_instr", {32'd0, f_instr}, 64'h77);
      chk("stall_f_pc", f_pc, 64'h2000);
    end
    drive(0, 0, 0, 0, 1, 64'h3000, 1);
    tick();
    chk("hold_redir_addr", ireq_addr, 64'h3000);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        r, ao, dok, rd, fr;
      logic [63:0] rt;
      r  = ($urandom_range(0, 99) == 0);
      rd = ($urandom_range(0, 7) == 0);
      rt = {$urandom, $urandom};
      fr = $urandom_range(0, 1) == 1;
      ao = 0;
      dok = 0;
      if (!m_held) begin
        if (!m_out) begin
          ao  = $urandom_range(0, 2) == 0;
          dok = ao && ($urandom_range(0, 1) == 1);
        end else begin
          dok = $urandom_range(0, 2) == 0;
        end
      end
      drive(r, ao, dok, $urandom, rd, rt, fr);
      tick();
    end

    // PC wrap on the second instance
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    w_reset = 0; w_addr_ok = 1; w_data_ok = 1; w_data = 32'h13;
    #1;
    chk("wrap_req_addr", w_ireq_addr, WrapPc);
    chk("wrap_pcplus4", w_pcplus4, 64'd0);
    @(posedge clk);
    @(negedge clk);
    w_addr_ok = 0; w_data_ok = 0; w_f_ready = 1;
    chk("wrap_f_valid", {63'd0, w_f_valid}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_next_addr", w_ireq_addr, 64'd0);
    chk("wrap_next_valid", {63'd0, w_ireq_valid}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end: owns the architectural fetch PC, issues one instruction-bus request at a time, and holds the returned instruction until decode accepts it. It is the consumer end of the next-PC selection path. It drives `pcplus4` into the next-PC mux and loads the selected PC (`pcselected`) back into its PC register on advance or redirect. Redirects (jump or exception) that arrive while a fetch is in flight cause the stale response to be discarded.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- redirect  input  1  next-PC mux is selecting a jump or exception target (jump | exception).
- pcselected  input  64  next PC from the selection mux; equals `pcplus4` when `redirect`=0.
- pcplus4  output  64  current PC + 4, feeds the selection mux.
- ireq_valid  output  1  instruction-bus request valid.
- ireq_addr  output  64  instruction-bus request address.
- iresp_addr_ok  input  1  bus accepted the request this cycle.
- iresp_data_ok  input  1  bus returns data this cycle.
- iresp_data  input  32  returned instruction word.
- f_valid  output  1  held instruction valid to decode.
- f_pc  output  64  PC of held instruction.
- f_instr  output  32  held instruction word.
- f_ready  input  1  decode accepts the instruction this cycle.

## Operation
- State: `pc` (64), `state` ∈ {REQ, WAIT, HOLD}, `discard` (1), `tgt` (64), `instr` (32).
- `pcplus4` = `pc` + 4, modulo 2^64. Wrap from 64'hFFFF_FFFF_FFFF_FFFC gives 0.
- `ireq_addr` = `pc`. `f_pc` = `pc`. `f_instr` = `instr`.
- PC low bits are not checked. Misaligned targets are fetched as-is; alignment faults are raised downstream.

REQ:
- `ireq_valid`=1.
- `ireq_addr` is held stable until `iresp_addr_ok`, even if `redirect` asserts.
- `redirect` in REQ: set `discard`=1, `tgt`=`pcselected`.
- On `addr_ok` with `data_ok`=0: go to WAIT.
- On `addr_ok` with `data_ok`=1 in the same cycle: treat as an immediate response, using the WAIT rules below.
- `data_ok` without `addr_ok` in REQ is ignored.

WAIT:
- `ireq_valid`=0.
- `redirect` sets `discard`=1 and `tgt`=`pcselected`. The latest redirect wins.
- On `data_ok` with `discard`=0: `instr`=`iresp_data`, go to HOLD.
- On `data_ok` with `discard`=1: `pc`=`tgt`, `discard`=0, go to REQ. The data is dropped.
- `redirect` in the same cycle as `data_ok`: the response is discarded, `pc`=`pcselected`, go to REQ.

HOLD:
- `f_valid`=1 and `ireq_valid`=0.
- `redirect`: `pc`=`pcselected`, go to REQ. The held instruction is killed. Redirect has priority over `f_ready`.
- `f_ready` without `redirect`: `pc`=`pcselected` (= `pcplus4`), go to REQ.
- With neither, hold all outputs stable.

Reset:
- `pc`=RESET_PC, `state`=REQ, `discard`=0, `tgt`=0, `instr`=0.
- While `reset`=1, `ireq_valid`=0 and `f_valid`=0.
- Reset mid-transaction abandons it. The bus shares the same reset, so no stale `data_ok` follows.

## Timing
- First request appears in the first cycle after `reset` deasserts.
- With a combinational bus (`addr_ok`&`data_ok` in the request cycle), `f_valid` rises one cycle after the request.
- Peak throughput with an immediate bus and `f_ready`=1 is one instruction per 2 cycles.
- Redirect to new request issue is 1 cycle from HOLD. From REQ/WAIT it is 1 cycle after the outstanding `data_ok`.
- `f_valid` and `ireq_valid` are never both 1.
- At most one transaction is outstanding.

## Test plan
- **Reset and first fetch.** Reset 3 cycles, release; bus answers `addr_ok`&`data_ok` immediately with 32'h00000013.
  - `ireq_addr`=0x80000000 in cycle 0, `f_valid`=1 in cycle 1 with `f_instr`=0x13.
  - With `f_ready`=1, the next request is 0x80000004.
- **Delayed bus.** `addr_ok` after 2 cycles, `data_ok` 3 cycles later.
  - `ireq_addr` is stable throughout REQ.
  - `f_valid` rises the cycle after `data_ok`.
  - No second request is issued in WAIT.
- **Redirect in WAIT.** Pulse `redirect` with `pcselected`=0x80001000, then return `data_ok` with 0xDEADBEEF.
  - `f_valid` never asserts for 0xDEADBEEF.
  - The next request is 0x80001000.
- **Redirect in REQ before `addr_ok`.** Assert `redirect` with `pcselected`=0x2000 for one cycle, then assert `addr_ok` 2 cycles later.
  - `ireq_addr` stays at the old PC until `addr_ok`.
  - The response is dropped and the next request is 0x2000.
- **Decode stall and HOLD redirect.**
  - Hold `f_ready`=0 for 5 cycles: `f_valid`, `f_pc` and `f_instr` stay stable.
  - Then assert `redirect` and `f_ready` together with `pcselected`=0x3000: the next request is 0x3000, not `pcplus4`.
- **PC wrap.** Force reset with RESET_PC=64'hFFFF_FFFF_FFFF_FFFC and accept one instruction.
  - `pcplus4`=0 and the next request is 0.
